qed_instruction_buffer: RTL and testbench
=========================================

Name: qed_instruction_buffer

Overview:
- SQED front-end stage between instruction fetch and decode, directly upstream of the register file's QED commit check.
- In ORIG mode it forwards original instructions, which are confined to x0–x15, and records them in a FIFO.
- In DUP mode it replays the recorded instructions, remapping every nonzero register index by +16 so that the duplicates operate on x16–x31.
- It produces the valid bit that travels down the pipeline and becomes qed_vld_out_ex_mem.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0).
- DUP_OFFSET, 16, register-index offset applied to duplicates.

Ports:
- clk  in  1  system clock
- outside_reset_n  in  1  asynchronous active-low reset
- qed_ena  in  1  1 = QED active; 0 = transparent pass-through
- ifu_qed_instruction  in  32  instruction from fetch
- stall  in  1  pipeline stall; freezes this block
- exec_dup  in  1  free or symbolic request to begin the duplicate phase
- qed_ifu_instruction  out  32  instruction sent to decode
- qed_vld_out  out  1  qualifies qed_ifu_instruction as a counted QED instruction
- qed_mode  out  1  0 = ORIG, 1 = DUP
- fifo_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async assert, sync release):
  - qed_ifu_instruction = NOP_INSTR, qed_vld_out = 0, qed_mode = ORIG.
  - FIFO empty; read and write pointers = 0.
- All outputs are registered: an input sampled at edge N appears after edge N; latency is 1 cycle.
- stall = 1: outputs hold; no push, no pop, no mode change. exec_dup is ignored during stall.
- qed_ena = 0: output = ifu_qed_instruction, qed_vld_out = 1, FIFO and mode held. Toggling qed_ena mid-run does not flush the FIFO.
- Register-field decode (by opcode[6:0]):
  - R (0110011): rd, rs1, rs2.
  - I (0010011, 0000011, 1100111): rd, rs1.
  - S (0100011), B (1100011): rs1, rs2.
  - U (0110111, 0010111), J (1101111): rd.
  - Other opcodes: treated as illegal.
- ORIG mode, not stalled:
  - Legal instruction, all used register fields < 16, FIFO not full: output the instruction unchanged, qed_vld_out = 1, push it.
  - Any used field >= 16, or illegal opcode: output NOP_INSTR, qed_vld_out = 0, no push.
- Transition ORIG→DUP, evaluated at each non-stalled edge:
  - Trigger: (exec_dup & fifo nonempty) | fifo full.
  - The transitioning cycle already outputs the first popped duplicate.
  - Full wins over everything: once full, no further push occurs and the cycle switches to DUP.
- DUP mode, not stalled:
  - Pop the head, apply the remap, output it with qed_vld_out = 1.
  - Fetched input is ignored; fetch is expected to be stalled externally.
- Remap (combinational):
  - Each used field f becomes (f == 0) ? 0 : f + DUP_OFFSET.
  - Opcode, funct and immediate bits are unchanged.
  - x0 stays x0, matching the commit counter's exclusion of rd == 0.
- Transition DUP→ORIG: on the cycle after the last pop, i.e. when the FIFO becomes empty. That cycle outputs an ORIG instruction normally.
- Simultaneous exec_dup and an incoming instruction in ORIG with FIFO nonempty: the incoming instruction is dropped (not pushed, not output); the duplicate wins.
- exec_dup with FIFO empty: ignored, stay ORIG.
- Pointers wrap modulo DEPTH. fifo_count never exceeds DEPTH and never underflows.
- Reset asserted mid-DUP: FIFO contents are discarded and the block returns to ORIG with all reset values.
- Invariant: over any ORIG-then-DUP episode, the number of vld instructions with rd in 1..15 equals the number with rd in 16..31.

Decomposition:
- Shared package qed_pkg holds:
  - opcode constants (OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL);
  - NOP_INSTR;
  - DUP_OFFSET;
  - the 1-bit mode encoding.
- One combinational sub-module, qed_modify_instruction, performs field decode, the legality check and the remap.
- The FIFO, FSM and output registers stay in the top module.

Test Plan:
- Reset, then feed add x1,x2,x3 (0x003100B3) → next cycle output 0x003100B3, vld = 1, fifo_count = 1.
- Pulse exec_dup → output 0x013908B3 (add x17,x18,x19), vld = 1, qed_mode = 1, then ORIG on the following cycle.
- Feed addi x1,x0,5 (0x00500093), then exec_dup → duplicate 0x00500893 (rs1 stays x0).
- Feed add x17,x1,x1 in ORIG → output 0x00000013, vld = 0, fifo_count unchanged.
- Push 8 legal instructions with exec_dup = 0 → mode is forced to DUP and 8 remapped duplicates emerge in order; stall asserted for 3 cycles mid-drain holds the output and count exactly.
- Assert outside_reset_n = 0 mid-DUP with fifo_count = 5 → immediate NOP, vld = 0, mode ORIG, count 0; after release, the next instruction passes through normally.

Source files
------------

// File: rtl/qed_pkg.sv
// Shared constants and register-field decode for the SQED instruction buffer.
// Everything here is pure combinational helpers, with no state.
package qed_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [4:0]  DUP_OFFSET = 5'd16;

    localparam logic MODE_ORIG = 1'b0;
    localparam logic MODE_DUP  = 1'b1;

    typedef struct packed {
        logic legal;
        logic use_rd;
        logic use_rs1;
        logic use_rs2;
    } reg_use_t;

    // Which register fields an opcode actually uses; unknown opcodes are illegal.
    function automatic reg_use_t decode_reg_use(input logic [6:0] opcode);
        reg_use_t u;
        u = '0;
        case (opcode)
            OPC_OP:                      u = '{legal: 1'b1, use_rd: 1'b1, use_rs1: 1'b1, use_rs2: 1'b1};
            OPC_OPIMM, OPC_LOAD, OPC_JALR: u = '{legal: 1'b1, use_rd: 1'b1, use_rs1: 1'b1, use_rs2: 1'b0};
            OPC_STORE, OPC_BRANCH:       u = '{legal: 1'b1, use_rd: 1'b0, use_rs1: 1'b1, use_rs2: 1'b1};
            OPC_LUI, OPC_AUIPC, OPC_JAL: u = '{legal: 1'b1, use_rd: 1'b1, use_rs1: 1'b0, use_rs2: 1'b0};
            default:                     u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/qed_modify_instruction.sv
// Combinational field decode: checks that a fetched instruction stays in x0-x15
// and produces the x16-x31 duplicate of the instruction at the FIFO head.
module qed_modify_instruction #(
    parameter logic [4:0] DUP_OFFSET = qed_pkg::DUP_OFFSET
) (
    input  logic [6:0]  fetch_opcode,
    input  logic [4:0]  fetch_rd,
    input  logic [4:0]  fetch_rs1,
    input  logic [4:0]  fetch_rs2,
    input  logic [31:0] head_instr,
    output logic        fetch_ok,
    output logic [31:0] dup_instr
);
    import qed_pkg::*;

    reg_use_t fetch_use;
    reg_use_t head_use;

    // x0 must stay x0 so the commit counter keeps ignoring it.
    function automatic logic [4:0] remap_field(input logic [4:0] f);
        return (f == 5'd0) ? 5'd0 : f + DUP_OFFSET;
    endfunction

    // NOTE: every variable written here is assigned a default first, so no latch can be inferred.
    always_comb begin
        fetch_use = decode_reg_use(fetch_opcode);
        fetch_ok  = fetch_use.legal
                    && !(fetch_use.use_rd  && fetch_rd[4])
                    && !(fetch_use.use_rs1 && fetch_rs1[4])
                    && !(fetch_use.use_rs2 && fetch_rs2[4]);
    end

    always_comb begin
        head_use  = decode_reg_use(head_instr[6:0]);
        dup_instr = head_instr;
        if (head_use.legal && head_use.use_rd)
            dup_instr[11:7] = remap_field(head_instr[11:7]);
        if (head_use.legal && head_use.use_rs1)
            dup_instr[19:15] = remap_field(head_instr[19:15]);
        if (head_use.legal && head_use.use_rs2)
            dup_instr[24:20] = remap_field(head_instr[24:20]);
    end

endmodule

// File: rtl/qed_instruction_buffer.sv
// SQED front-end buffer: forwards and records original instructions, then replays
// them with registers remapped to x16-x31. All outputs are registered.
module qed_instruction_buffer #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] NOP_INSTR  = qed_pkg::NOP_INSTR,
    parameter logic [4:0]  DUP_OFFSET = qed_pkg::DUP_OFFSET
) (
    input  logic                   clk,
    input  logic                   outside_reset_n,
    input  logic                   qed_ena,
    input  logic [31:0]            ifu_qed_instruction,
    input  logic                   stall,
    input  logic                   exec_dup,
    output logic [31:0]            qed_ifu_instruction,
    output logic                   qed_vld_out,
    output logic                   qed_mode,
    output logic [$clog2(DEPTH):0] fifo_count
);
    import qed_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic          fifo_empty;
    logic          fifo_full;
    logic          start_dup;
    logic          do_push;
    logic          do_pop;
    logic [31:0]   instr_d;
    logic          vld_d;
    logic          mode_d;
    logic          fetch_ok;
    logic [31:0]   dup_instr;

    qed_modify_instruction #(
        .DUP_OFFSET (DUP_OFFSET)
    ) u_modify (
        .fetch_opcode (ifu_qed_instruction[6:0]),
        .fetch_rd     (ifu_qed_instruction[11:7]),
        .fetch_rs1    (ifu_qed_instruction[19:15]),
        .fetch_rs2    (ifu_qed_instruction[24:20]),
        .head_instr   (mem[rd_ptr]),
        .fetch_ok     (fetch_ok),
        .dup_instr    (dup_instr)
    );

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(DEPTH));

    // Staying in DUP, an explicit request, or a full FIFO all pop; a DUP cycle
    // that finds the FIFO empty falls through to normal ORIG handling.
    assign start_dup = !fifo_empty && (qed_mode == MODE_DUP || exec_dup || fifo_full);

    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        instr_d = qed_ifu_instruction;
        vld_d   = qed_vld_out;
        mode_d  = qed_mode;
        if (!stall) begin
            if (!qed_ena) begin
                instr_d = ifu_qed_instruction;
                vld_d   = 1'b1;
            end else if (start_dup) begin
                do_pop  = 1'b1;
                instr_d = dup_instr;
                vld_d   = 1'b1;
                mode_d  = MODE_DUP;
            end else begin
                mode_d = MODE_ORIG;
                if (fetch_ok) begin
                    do_push = 1'b1;
                    instr_d = ifu_qed_instruction;
                    vld_d   = 1'b1;
                end else begin
                    instr_d = NOP_INSTR;
                    vld_d   = 1'b0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge outside_reset_n) begin
        if (!outside_reset_n) begin
            qed_ifu_instruction <= NOP_INSTR;
            qed_vld_out         <= 1'b0;
            qed_mode            <= MODE_ORIG;
            fifo_count          <= '0;
            rd_ptr              <= '0;
            wr_ptr              <= '0;
        end else begin
            qed_ifu_instruction <= instr_d;
            qed_vld_out         <= vld_d;
            qed_mode            <= mode_d;
            if (do_push) begin
                wr_ptr     <= wr_ptr + AW'(1);
                fifo_count <= fifo_count + CW'(1);
            end else if (do_pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= ifu_qed_instruction;
    end

endmodule

// File: tb/tb_qed_instruction_buffer.sv
// Self-checking bench for qed_instruction_buffer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_qed_instruction_buffer;

    localparam int          DEPTH = 8;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        outside_reset_n;
    logic        qed_ena;
    logic [31:0] ifu_qed_instruction;
    logic        stall;
    logic        exec_dup;
    logic [31:0] qed_ifu_instruction;
    logic        qed_vld_out;
    logic        qed_mode;
    logic [3:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_q[$];
    bit          m_dup;
    logic [31:0] m_out;
    bit          m_vld;

    qed_instruction_buffer #(.DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .outside_reset_n     (outside_reset_n),
        .qed_ena             (qed_ena),
        .ifu_qed_instruction (ifu_qed_instruction),
        .stall               (stall),
        .exec_dup            (exec_dup),
        .qed_ifu_instruction (qed_ifu_instruction),
        .qed_vld_out         (qed_vld_out),
        .qed_mode            (qed_mode),
        .fifo_count          (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {rd, rs1, rs2} usage per opcode; 0 means illegal.
    function automatic logic [2:0] used_fields(input logic [6:0] opc);
        case (opc)
            7'b0110011:                         return 3'b111;
            7'b0010011, 7'b0000011, 7'b1100111: return 3'b110;
            7'b0100011, 7'b1100011:             return 3'b011;
            7'b0110111, 7'b0010111, 7'b1101111: return 3'b100;
            default:                            return 3'b000;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [31:0] w);
        logic [2:0] m;
        int pos[3];
        m = used_fields(w[6:0]);
        pos = '{7, 15, 20};
        if (m == 3'b000) return 1'b0;
        for (int k = 0; k < 3; k++)
            if (m[2-k] && w[pos[k] +: 5] >= 5'd16) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_remap(input logic [31:0] w);
        logic [2:0] m;
        int pos[3];
        m = used_fields(w[6:0]);
        pos = '{7, 15, 20};
        for (int k = 0; k < 3; k++)
            if (m[2-k] && w[pos[k] +: 5] != 5'd0) w[pos[k] +: 5] = w[pos[k] +: 5] + 5'd16;
        return w;
    endfunction

    function automatic logic [31:0] gen_instr(input bit allow_bad);
        logic [6:0]  opcs[9];
        logic [31:0] w;
        opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
        w = $urandom;
        w[6:0] = opcs[$urandom_range(0, 8)];
        if (allow_bad && $urandom_range(0, 9) == 0) w[6:0] = 7'b0001111;
        w[11:7]  = (allow_bad && $urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
        w[19:15] = (allow_bad && $urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
        w[24:20] = (allow_bad && $urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
        return w;
    endfunction

    task automatic model_step(input logic [31:0] instr, input bit ena, input bit stl, input bit dup);
        if (stl) return;
        if (!ena) begin
            m_out = instr;
            m_vld = 1'b1;
        end else if (m_q.size() != 0 && (m_dup || dup || m_q.size() == DEPTH)) begin
            m_out = ref_remap(m_q.pop_front());
            m_vld = 1'b1;
            m_dup = 1'b1;
        end else begin
            m_dup = 1'b0;
            if (ref_legal(instr)) begin
                m_q.push_back(instr);
                m_out = instr;
                m_vld = 1'b1;
            end else begin
                m_out = NOP;
                m_vld = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dup = 1'b0;
        m_out = NOP;
        m_vld = 1'b0;
    endtask

    // Drive at the falling edge, let the rising edge act, return at the next falling edge.
    task automatic cycle(input logic [31:0] instr, input bit ena, input bit stl, input bit dup);
        ifu_qed_instruction = instr;
        qed_ena             = ena;
        stall               = stl;
        exec_dup            = dup;
        @(posedge clk);
        model_step(instr, ena, stl, dup);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        outside_reset_n     = 1'b0;
        qed_ena             = 1'b1;
        stall               = 1'b0;
        exec_dup            = 1'b0;
        ifu_qed_instruction = NOP;
        model_reset();
        repeat (2) @(negedge clk);
        outside_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (qed_ifu_instruction !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", qed_ifu_instruction, NOP); end
        checks++; if (qed_vld_out !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", qed_vld_out); end
        checks++; if (qed_mode !== 1'b0) begin errors++; $display("FAIL reset_mode: got %b expected 0", qed_mode); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    endtask

    typedef struct {
        logic [31:0] instr;
        bit          ena;
        bit          dup;
        logic [31:0] out;
        bit          vld;
        bit          mode;
        int          cnt;
    } step_t;

    task automatic run_table(input string name, input step_t tbl[]);
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].instr, tbl[i].ena, 1'b0, tbl[i].dup);
            checks++; if (qed_ifu_instruction !== tbl[i].out) begin errors++; $display("FAIL %s[%0d]_instr: got %h expected %h", name, i, qed_ifu_instruction, tbl[i].out); end
            checks++; if (qed_vld_out !== tbl[i].vld) begin errors++; $display("FAIL %s[%0d]_vld: got %b expected %b", name, i, qed_vld_out, tbl[i].vld); end
            checks++; if (qed_mode !== tbl[i].mode) begin errors++; $display("FAIL %s[%0d]_mode: got %b expected %b", name, i, qed_mode, tbl[i].mode); end
            checks++; if (fifo_count !== 4'(tbl[i].cnt)) begin errors++; $display("FAIL %s[%0d]_count: got %0d expected %0d", name, i, fifo_count, tbl[i].cnt); end
        end
    endtask

    task automatic test_basic();
        step_t tbl[];
        apply_reset();
        tbl = new[7];
        tbl[0] = '{32'h003100B3, 1'b1, 1'b0, 32'h003100B3, 1'b1, 1'b0, 1};  // add x1,x2,x3
        tbl[1] = '{32'h00208133, 1'b1, 1'b1, 32'h013908B3, 1'b1, 1'b1, 0};  // dup wins, input dropped
        tbl[2] = '{32'h00500093, 1'b1, 1'b0, 32'h00500093, 1'b1, 1'b0, 1};  // back to ORIG
        tbl[3] = '{32'h003100B3, 1'b1, 1'b1, 32'h00500893, 1'b1, 1'b1, 0};  // rs1 x0 stays x0
        tbl[4] = '{32'h001088B3, 1'b1, 1'b0, NOP,          1'b0, 1'b0, 0};  // rd x17 rejected
        tbl[5] = '{32'h003100B3, 1'b1, 1'b1, 32'h003100B3, 1'b1, 1'b0, 1};  // exec_dup on empty FIFO
        tbl[6] = '{32'hFFFFFFFF, 1'b1, 1'b0, NOP,          1'b0, 1'b0, 1};  // illegal opcode
        run_table("basic", tbl);
    endtask

    task automatic test_ena_bypass();
        step_t tbl[];
        tbl = new[3];
        tbl[0] = '{32'h001088B3, 1'b0, 1'b1, 32'h001088B3, 1'b1, 1'b0, 1};  // transparent, FIFO held
        tbl[1] = '{32'hFFFFFFFF, 1'b1, 1'b1, 32'h013908B3, 1'b1, 1'b1, 0};  // entry survived
        tbl[2] = '{32'hFFFFFFFF, 1'b1, 1'b0, NOP,          1'b0, 1'b0, 0};
        run_table("bypass", tbl);
    endtask

    task automatic test_full_drain();
        logic [31:0] pushed[DEPTH];
        logic [31:0] w;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            pushed[i] = gen_instr(1'b0);
            cycle(pushed[i], 1'b1, 1'b0, 1'b0);
            checks++; if (fifo_count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, fifo_count, i + 1); end
        end
        checks++; if (qed_mode !== 1'b0) begin errors++; $display("FAIL fill_mode: got %b expected 0", qed_mode); end
        for (int k = 0; k < DEPTH; k++) begin
            cycle(gen_instr(1'b0), 1'b1, 1'b0, 1'b0);
            checks++; if (qed_ifu_instruction !== ref_remap(pushed[k])) begin errors++; $display("FAIL drain_instr[%0d]: got %h expected %h", k, qed_ifu_instruction, ref_remap(pushed[k])); end
            checks++; if (qed_vld_out !== 1'b1 || qed_mode !== 1'b1) begin errors++; $display("FAIL drain_vld_mode[%0d]: got %b%b expected 11", k, qed_vld_out, qed_mode); end
            checks++; if (fifo_count !== 4'(DEPTH - 1 - k)) begin errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", k, fifo_count, DEPTH - 1 - k); end
            if (k == 2) begin
                for (int s = 0; s < 3; s++) begin
                    cycle(gen_instr(1'b1), 1'b1, 1'b1, 1'($urandom_range(0, 1)));
                    checks++; if (qed_ifu_instruction !== ref_remap(pushed[2])) begin errors++; $display("FAIL stall_instr[%0d]: got %h expected %h", s, qed_ifu_instruction, ref_remap(pushed[2])); end
                    checks++; if (fifo_count !== 4'd5 || qed_mode !== 1'b1) begin errors++; $display("FAIL stall_state[%0d]: got count %0d mode %b expected 5 1", s, fifo_count, qed_mode); end
                end
            end
        end
        w = gen_instr(1'b0);
        cycle(w, 1'b1, 1'b0, 1'b0);
        checks++; if (qed_ifu_instruction !== w || qed_mode !== 1'b0 || fifo_count !== 4'd1) begin
            errors++; $display("FAIL drain_return: got %h mode %b count %0d expected %h 0 1", qed_ifu_instruction, qed_mode, fifo_count, w);
        end
    endtask

    task automatic test_reset_mid_dup();
        apply_reset();
        for (int i = 0; i < DEPTH + 3; i++) cycle(gen_instr(1'b0), 1'b1, 1'b0, 1'b0);
        checks++; if (fifo_count !== 4'd5 || qed_mode !== 1'b1) begin errors++; $display("FAIL middup_pre: got count %0d mode %b expected 5 1", fifo_count, qed_mode); end
        #2;
        outside_reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (qed_ifu_instruction !== NOP || qed_vld_out !== 1'b0) begin errors++; $display("FAIL middup_out: got %h vld %b expected %h 0", qed_ifu_instruction, qed_vld_out, NOP); end
        checks++; if (qed_mode !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL middup_state: got mode %b count %0d expected 0 0", qed_mode, fifo_count); end
        @(negedge clk);
        outside_reset_n = 1'b1;
        cycle(32'h003100B3, 1'b1, 1'b0, 1'b0);
        checks++; if (qed_ifu_instruction !== 32'h003100B3 || qed_vld_out !== 1'b1 || fifo_count !== 4'd1) begin
            errors++; $display("FAIL middup_after: got %h vld %b count %0d expected 003100b3 1 1", qed_ifu_instruction, qed_vld_out, fifo_count);
        end
    endtask

    task automatic test_random();
        int          lo = 0;
        int          hi = 0;
        int          bad = 0;
        bit          ena;
        bit          stl;
        logic [2:0]  m;
        logic [4:0]  rd;
        apply_reset();
        for (int i = 0; i < 3000 + DEPTH + 2; i++) begin
            if (i < 3000) begin
                ena = ($urandom_range(0, 15) != 0);
                stl = ($urandom_range(0, 4) == 0);
                cycle(gen_instr(1'b1), ena, stl, ($urandom_range(0, 5) == 0));
            end else begin
                ena = 1'b1;
                stl = 1'b0;
                cycle(32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
            end
            if (qed_ifu_instruction !== m_out || qed_vld_out !== m_vld || qed_mode !== m_dup || fifo_count !== 4'(m_q.size())) begin
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: got %h/%b/%b/%0d expected %h/%b/%b/%0d", i, qed_ifu_instruction, qed_vld_out, qed_mode, fifo_count, m_out, m_vld, m_dup, m_q.size());
            end
            if (ena && !stl && qed_vld_out === 1'b1) begin
                m  = used_fields(qed_ifu_instruction[6:0]);
                rd = qed_ifu_instruction[11:7];
                if (m[2] && rd >= 5'd1 && rd <= 5'd15) lo++;
                if (m[2] && rd >= 5'd16) hi++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL random_model: %0d cycles disagreed with the reference model", bad); end
        checks++; if (lo != hi) begin errors++; $display("FAIL rd_balance: got %0d duplicates with rd>=16 expected %0d", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ena_bypass();
        test_full_drain();
        test_reset_mid_dup();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
